// File: rtl/keypad_event_scanner.sv
// Row-strobed keypad scanner with per-key debounce and a
// first-word-fall-through press/release event queue.
module keypad_event_scanner #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int K  = ROWS * COLS,
  localparam int KW = (K > 1) ? $clog2(K) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [COLS-1:0] keyCol,
  output logic [ROWS-1:0] keyRow,
  output logic            key_valid,
  input  logic            key_ready,
  output logic [KW-1:0]   key_code,
  output logic            key_press,
  output logic            key_down,
  output logic            overflow
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [0:0] {
    S_SCAN,
    S_EVAL
  } state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   idx_q, idx_d;
  logic [COLS-1:0] sync1, sync2;
  logic [DW-1:0]   dwell_q;
  logic [RW-1:0]   row_q;
  logic [K-1:0]    raw_q;
  logic [K-1:0]    stable_q, stable_d;
  logic [CW-1:0]   cnt_q [K];
  logic [CW-1:0]   cnt_d;
  logic            flip;
  logic            ev_press;
  logic            key_down_q;
  logic            sample;
  logic            frame_end;

  assign sample    = dwell_q == DW'(SCAN_DIV - 1);
  assign frame_end = sample && (row_q == RW'(ROWS - 1));
  assign keyRow    = ~(ROWS'(1) << row_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1   <= '1;
      sync2   <= '1;
      dwell_q <= '0;
      row_q   <= '0;
      raw_q   <= '0;
    end else begin
      sync1 <= keyCol;
      sync2 <= sync1;
      if (sample) begin
        dwell_q <= '0;
        if (row_q == RW'(ROWS - 1))
          row_q <= '0;
        else
          row_q <= row_q + RW'(1);
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++)
            if (row_q == RW'(r))
              raw_q[r*COLS+c] <= ~sync2[c];
      end else begin
        dwell_q <= dwell_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_SCAN;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // One key per cycle after each frame end, in ascending order
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_SCAN: begin
        if (frame_end) begin
          state_d = S_EVAL;
          idx_d   = '0;
        end
      end
      S_EVAL: begin
        if (idx_q == KW'(K - 1)) begin
          state_d = S_SCAN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + KW'(1);
        end
      end
    endcase
  end

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    flip     = 1'b0;
    ev_press = ~stable_q[idx_q];
    if (state_q == S_EVAL) begin
      if (raw_q[idx_q] != stable_q[idx_q]) begin
        if (cnt_q[idx_q] + CW'(1) == CW'(DEBOUNCE)) begin
          flip            = 1'b1;
          stable_d[idx_q] = ~stable_q[idx_q];
        end else begin
          cnt_d = cnt_q[idx_q] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stable_q   <= '0;
      key_down_q <= 1'b0;
      for (int k = 0; k < K; k++)
        cnt_q[k] <= '0;
    end else begin
      stable_q   <= stable_d;
      key_down_q <= |stable_d;
      if (state_q == S_EVAL)
        cnt_q[idx_q] <= cnt_d;
    end
  end

  assign key_down = key_down_q;

  logic [KW:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic [KW:0] head;
  logic        empty, full;
  logic        pop, wr_en, drop;

  assign empty = wr_q == rd_q;
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop   = !empty && key_ready;
  // A full queue still accepts a push when the head leaves this cycle
  assign wr_en = flip && (!full || pop);
  assign drop  = flip && full && !pop;
  assign head  = mem[rd_q[AW-1:0]];

  always_ff @(posedge clock) begin
    if (wr_en)
      mem[wr_q[AW-1:0]] <= {idx_q, ev_press};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q     <= '0;
      rd_q     <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en)
        wr_q <= wr_q + {{AW{1'b0}}, 1'b1};
      if (pop)
        rd_q <= rd_q + {{AW{1'b0}}, 1'b1};
      if (drop)
        overflow <= 1'b1;
    end
  end

  assign key_valid = !empty;
  assign key_code  = empty ? '0 : head[KW:1];
  assign key_press = !empty && head[0];

endmodule

// File: tb/tb_keypad_event_scanner.sv
// Directed and randomized checks of keypad_event_scanner
// against a frame-level behavioural model.
module tb_keypad_event_scanner;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int SD    = 20;
  localparam int DEB   = 2;
  localparam int DEPTH = 4;
  localparam int K     = ROWS * COLS;
  localparam int FRAME = ROWS * SD;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [COLS-1:0] keyCol = '1;
  logic [ROWS-1:0] keyRow;
  logic            key_valid;
  logic            key_ready = 1'b0;
  logic [3:0]      key_code;
  logic            key_press;
  logic            key_down;
  logic            overflow;

  keypad_event_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SD),
    .DEBOUNCE(DEB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset), .keyCol(keyCol),
    .keyRow(keyRow), .key_valid(key_valid),
    .key_ready(key_ready), .key_code(key_code),
    .key_press(key_press), .key_down(key_down),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit [K-1:0] closed;
  bit [K-1:0] raw_m;
  bit [K-1:0] st_m;
  int         cnt_m [K];
  int         q [$];
  bit         ovf_m;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic model_clear();
    raw_m = '0;
    st_m  = '0;
    foreach (cnt_m[i]) cnt_m[i] = 0;
    q.delete();
    ovf_m = 1'b0;
    cyc   = 0;
  endtask

  // Effects of cycle cyc, giving the visible state of cyc+1
  task automatic model_cycle();
    int  t;
    int  k;
    int  r;
    bit  pop;
    bit  ev;
    int  evv;
    t   = cyc;
    pop = key_ready && (q.size() > 0);
    ev  = 1'b0;
    evv = 0;
    if (t >= FRAME && (t % FRAME) < K) begin
      k = t % FRAME;
      if (raw_m[k] == st_m[k]) begin
        cnt_m[k] = 0;
      end else begin
        cnt_m[k]++;
        if (cnt_m[k] == DEB) begin
          st_m[k]  = !st_m[k];
          cnt_m[k] = 0;
          ev       = 1'b1;
          evv      = k * 2 + int'(st_m[k]);
        end
      end
    end
    if (t % SD == SD - 1) begin
      r = (t / SD) % ROWS;
      for (int c = 0; c < COLS; c++)
        raw_m[r*COLS+c] = closed[r*COLS+c];
    end
    if (pop) void'(q.pop_front());
    if (ev) begin
      if (q.size() < DEPTH) q.push_back(evv);
      else ovf_m = 1'b1;
    end
    cyc++;
  endtask

  task automatic drive_col();
    logic [COLS-1:0] col;
    col = '1;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        if (keyRow[r] === 1'b0 && closed[r*COLS+c])
          col[c] = 1'b0;
    keyCol = col;
  endtask

  task automatic check_all();
    logic [ROWS-1:0] er;
    er = ~(ROWS'(1) << ((cyc / SD) % ROWS));
    chk("keyRow", keyRow, er);
    chk("key_valid", key_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("key_code", key_code, q[0] / 2);
      chk("key_press", key_press, q[0] % 2);
    end
    chk("key_down", key_down, |st_m);
    chk("overflow", overflow, ovf_m);
  endtask

  task automatic step();
    drive_col();
    if (reset) model_clear();
    else model_cycle();
    @(posedge clock);
    @(negedge clock);
    drive_col();
    check_all();
  endtask

  task automatic run_until(int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    key_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_row"}, keyRow, 4'b1110);
    chk({tag, "_valid"}, key_valid, 0);
    chk({tag, "_code"}, key_code, 0);
    chk({tag, "_press"}, key_press, 0);
    chk({tag, "_down"}, key_down, 0);
    chk({tag, "_ovf"}, overflow, 0);
  endtask

  task automatic drain(input int codes[4]);
    key_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", key_valid, 1);
      chk("drain_code", key_code, codes[i]);
      step();
    end
    key_ready = 1'b0;
    chk("drain_empty", key_valid, 0);
  endtask

  bit [K-1:0] multi;

  initial begin
    multi = '0;
    multi[0] = 1'b1;
    multi[3] = 1'b1;
    multi[5] = 1'b1;
    multi[9] = 1'b1;
    multi[15] = 1'b1;

    // press from reset, then pop and release
    closed = '0;
    do_reset();
    chk_reset_vals("rst");
    closed = K'(1) << 6;
    run_until(160);
    closed = '0;
    run_until(166);
    chk("s1_pre_valid", key_valid, 0);
    chk("s1_pre_down", key_down, 0);
    step();
    chk("s1_valid", key_valid, 1);
    chk("s1_code", key_code, 6);
    chk("s1_press", key_press, 1);
    chk("s1_down", key_down, 1);
    run_until(200);
    key_ready = 1'b1;
    step();
    key_ready = 1'b0;
    chk("s3_popped", key_valid, 0);
    run_until(326);
    chk("s3_pre_down", key_down, 1);
    chk("s3_pre_valid", key_valid, 0);
    step();
    chk("s3_valid", key_valid, 1);
    chk("s3_code", key_code, 6);
    chk("s3_press", key_press, 0);
    chk("s3_down", key_down, 0);
    run_until(340);

    // single-frame bounce
    do_reset();
    closed = K'(1) << 6;
    run_until(80);
    closed = '0;
    run_until(260);
    chk("s2_down", key_down, 0);
    chk("s2_valid", key_valid, 0);

    // multi-key ordering and overflow
    do_reset();
    closed = multi;
    run_until(176);
    chk("s4_ovf", overflow, 1);
    run_until(180);
    drain('{0, 3, 5, 9});
    chk("s4_ovf_sticky", overflow, 1);

    // push and pop on a full queue
    do_reset();
    closed = multi;
    run_until(175);
    chk("s5_full_head", key_code, 0);
    key_ready = 1'b1;
    step();
    key_ready = 1'b0;
    chk("s5_no_ovf", overflow, 0);
    run_until(180);
    drain('{3, 5, 9, 15});
    chk("s5_ovf_end", overflow, 0);

    // reset in the middle of debouncing
    do_reset();
    closed = K'(1) << 6;
    run_until(120);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_reset_vals("s6");
    run_until(166);
    chk("s6_pre_valid", key_valid, 0);
    step();
    chk("s6_valid", key_valid, 1);
    chk("s6_code", key_code, 6);
    chk("s6_press", key_press, 1);

    // randomized keys and consumer
    do_reset();
    closed = '0;
    while (cyc < 10 * FRAME) begin
      if (cyc % (2 * FRAME) == 0)
        closed = K'($urandom & $urandom);
      key_ready = ($urandom_range(0, 3) == 0);
      step();
    end
    key_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
